// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller.
// Reads the current PC, issues single-outstanding instruction-memory reads,
// steers the PC register (sequential +4 or branch/jump redirect) and buffers
// fetched words in a small FIFO that decode drains over valid/ready.
// A redirect flushes the buffer and marks any in-flight response as stale.
module instr_fetch_ctrl #(
   parameter int N     = 10,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  pc_i,
   output logic [31:0]   next_pc_o,
   output logic          pc_en_o,
   output logic          imem_req_o,
   output logic [N-1:0]  imem_addr_o,
   input  logic          imem_gnt_i,
   input  logic          imem_rvalid_i,
   input  logic [31:0]   imem_rdata_i,
   input  logic          redirect_i,
   input  logic [31:0]   redirect_pc_i,
   output logic          if_valid_o,
   output logic [31:0]   if_instr_o,
   output logic [N-1:0]  if_pc_o,
   input  logic          if_ready_i
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // IDLE: nothing outstanding; WAIT: response will be kept;
   // DROP: response belongs to a flushed path and is thrown away.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state;
   logic            run;
   logic [CW-1:0]   count;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [N-1:0]    req_pc_p0;

   logic [31:0]     instr_mem [DEPTH];
   logic [N-1:0]    pc_mem    [DEPTH];

   logic            has_room;
   logic            req;
   logic            grant;
   logic            push;
   logic            pop;
   logic            buf_valid;
   logic [31:0]     pc_ext;
   logic            unused_redirect_lsbs;

   // Redirect targets are word aligned; the two low bits are deliberately dropped.
   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   // Credit gate: never request unless the buffer can take the answer.
   assign has_room  = (count < FULL_CNT);
   assign req       = run & (state == IDLE) & ~redirect_i & has_room;
   assign grant     = req & imem_gnt_i;

   // A response arriving in the redirect cycle is stale even while in WAIT.
   assign push      = (state == WAIT) & imem_rvalid_i & ~redirect_i;
   assign buf_valid = (count != '0);
   assign pop       = buf_valid & if_ready_i;

   assign imem_req_o  = req;
   assign imem_addr_o = pc_i;

   // The PC register keeps only N bits, so the 32-bit sum wraps there.
   assign pc_ext    = {{(32 - N){1'b0}}, pc_i};
   assign next_pc_o = redirect_i ? {redirect_pc_i[31:2], 2'b00} : (pc_ext + 32'd4);
   assign pc_en_o   = grant | redirect_i;

   // Head of the buffer; outputs read as zero whenever nothing is buffered.
   assign if_valid_o = buf_valid;
   assign if_instr_o = buf_valid ? instr_mem[rd_ptr] : 32'd0;
   assign if_pc_o    = buf_valid ? pc_mem[rd_ptr]    : '0;

   // Run flag: fetching starts on the first edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // Outstanding-request tracker: one request at most, kept or dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid_i) begin
                  state <= IDLE;
               end else if (redirect_i) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (imem_rvalid_i) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Remember the address of the granted request so the response can be tagged.
   always_ff @(posedge clk) begin
      if (grant) begin
         req_pc_p0 <= pc_i;
      end
   end

   // Buffer occupancy and pointers; a redirect flushes and beats a same-cycle pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (redirect_i) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Buffer storage: instruction word together with the address it came from.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_rdata_i;
         pc_mem[wr_ptr]    <= req_pc_p0;
      end
   end

endmodule
